// File: rtl/ysyx_23060221_axi_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060221_axi_pkg
// Shared AXI definitions for the read and write arbiters:
//   - arbiter FSM state encoding (3-bit enum)
//   - AXI burst / size / response constants
//   - axi_size_bytes(): bytes per beat for an AxSIZE code
// ---------------------------------------------------------------------------
package ysyx_23060221_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR0  = 3'd1,
    ST_AR1  = 3'd2,
    ST_R0   = 3'd3,
    ST_R1   = 3'd4
  } axi_arb_state_e;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic [7:0] axi_size_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/ysyx_23060221_axi_rd_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060221_axi_rd_if
// AXI4 read-channel bundle (AR + R).
//   master modport: drives ar* request and rready, receives arready and r*.
//   slave  modport: drives arready and r*, receives ar* request and rready.
// Parameters: ADDR_W, DATA_W, ID_W.
// ---------------------------------------------------------------------------
interface ysyx_23060221_axi_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/ysyx_23060221_rr_pick.sv
// ---------------------------------------------------------------------------
// ysyx_23060221_rr_pick
// Two-way picker, combinational.
//   req[1:0]    request per master
//   last_grant  master granted most recently (0/1)
//   fix_prio    1: master 1 wins ties; 0: the master that was not last wins
//   grant[1:0]  one-hot grant, '0 when nothing requests
// ---------------------------------------------------------------------------
module ysyx_23060221_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fix_prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (fix_prio || !last_grant) ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060221_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060221_axi_rd_arbiter
// Two-master, one-slave AXI4 read arbiter (IFU = m0, LSU = m1).
// One transaction in flight; ownership runs from AR accept to the rlast beat.
// Ports:
//   clk, rst  clock (rising edge), asynchronous active-high reset
//   m0, m1    slave-side read bundles facing the IFU / LSU
//   s         master-side read bundle facing the memory slave
//   busy      1 whenever the FSM is not IDLE
// Parameters: ADDR_W, DATA_W, ID_W (bus widths), FIX_PRIO (0 RR, 1 m1 wins).
// ---------------------------------------------------------------------------
module ysyx_23060221_axi_rd_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int FIX_PRIO = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_23060221_axi_rd_if.slave   m0,
  ysyx_23060221_axi_rd_if.slave   m1,
  ysyx_23060221_axi_rd_if.master  s,
  output logic                    busy
);
  import ysyx_23060221_axi_pkg::*;

  axi_arb_state_e state;
  logic           last_grant;
  logic [1:0]     req;
  logic [1:0]     grant;

  logic [ADDR_W-1:0] ar_addr;
  logic [ID_W-1:0]   ar_id;
  logic [DATA_W-1:0] r_data;
  logic [ID_W-1:0]   r_id;

  assign req = {m1.arvalid, m0.arvalid};

  ysyx_23060221_rr_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .fix_prio   (FIX_PRIO != 0),
    .grant      (grant)
  );

  // busy is written alongside every state transition so it is exactly
  // (state != IDLE) while still coming straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant[0]) begin
            state <= ST_AR0;
            busy  <= 1'b1;
          end else if (grant[1]) begin
            state <= ST_AR1;
            busy  <= 1'b1;
          end
        end
        ST_AR0: begin
          if (!m0.arvalid) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (s.arready) begin
            state      <= ST_R0;
            last_grant <= 1'b0;
          end
        end
        ST_AR1: begin
          if (!m1.arvalid) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (s.arready) begin
            state      <= ST_R1;
            last_grant <= 1'b1;
          end
        end
        ST_R0: begin
          if (s.rvalid && m0.rready && s.rlast) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_R1: begin
          if (s.rvalid && m1.rready && s.rlast) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // AR channel mux: only the granted master sees arready.
  always_comb begin
    s.arvalid  = 1'b0;
    ar_addr    = '0;
    ar_id      = '0;
    s.arlen    = '0;
    s.arsize   = '0;
    s.arburst  = '0;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    case (state)
      ST_AR0: begin
        s.arvalid  = m0.arvalid;
        ar_addr    = m0.araddr;
        ar_id      = m0.arid;
        s.arlen    = m0.arlen;
        s.arsize   = m0.arsize;
        s.arburst  = m0.arburst;
        m0.arready = s.arready;
      end
      ST_AR1: begin
        s.arvalid  = m1.arvalid;
        ar_addr    = m1.araddr;
        ar_id      = m1.arid;
        s.arlen    = m1.arlen;
        s.arsize   = m1.arsize;
        s.arburst  = m1.arburst;
        m1.arready = s.arready;
      end
      default: ;
    endcase
  end

  assign s.araddr = ar_addr;
  assign s.arid   = ar_id;
  assign r_data   = s.rdata;
  assign r_id     = s.rid;

  // R channel mux: routed purely by state, rid is passed through unchecked.
  always_comb begin
    s.rready  = 1'b0;
    m0.rvalid = 1'b0;
    m0.rdata  = '0;
    m0.rresp  = '0;
    m0.rlast  = 1'b0;
    m0.rid    = '0;
    m1.rvalid = 1'b0;
    m1.rdata  = '0;
    m1.rresp  = '0;
    m1.rlast  = 1'b0;
    m1.rid    = '0;
    case (state)
      ST_R0: begin
        s.rready  = m0.rready;
        m0.rvalid = s.rvalid;
        m0.rdata  = r_data;
        m0.rresp  = s.rresp;
        m0.rlast  = s.rlast;
        m0.rid    = r_id;
      end
      ST_R1: begin
        s.rready  = m1.rready;
        m1.rvalid = s.rvalid;
        m1.rdata  = r_data;
        m1.rresp  = s.rresp;
        m1.rlast  = s.rlast;
        m1.rid    = r_id;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060221_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060221_axi_rd_arbiter
// Directed bench: dut_rr (FIX_PRIO=0) and dut_fx (FIX_PRIO=1) share clk/rst.
// ---------------------------------------------------------------------------
module tb_ysyx_23060221_axi_rd_arbiter;
  import ysyx_23060221_axi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy_a, busy_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_23060221_axi_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m0a ();
  ysyx_23060221_axi_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m1a ();
  ysyx_23060221_axi_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) sa ();
  ysyx_23060221_axi_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m0b ();
  ysyx_23060221_axi_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m1b ();
  ysyx_23060221_axi_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) sb ();

  ysyx_23060221_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .FIX_PRIO(0)) dut_rr (
    .clk (clk), .rst (rst), .m0 (m0a), .m1 (m1a), .s (sa), .busy (busy_a)
  );

  ysyx_23060221_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .FIX_PRIO(1)) dut_fx (
    .clk (clk), .rst (rst), .m0 (m0b), .m1 (m1b), .s (sb), .busy (busy_b)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rvalid(input int m);
    return (m == 1) ? m1a.rvalid : m0a.rvalid;
  endfunction

  function automatic logic [31:0] get_rdata(input int m);
    return (m == 1) ? m1a.rdata : m0a.rdata;
  endfunction

  function automatic logic get_arready(input int m);
    return (m == 1) ? m1a.arready : m0a.arready;
  endfunction

  task automatic clear_inputs();
    m0a.arvalid = 0; m0a.araddr = '0; m0a.arid = '0; m0a.arlen = '0;
    m0a.arsize = '0; m0a.arburst = '0; m0a.rready = 1;
    m1a.arvalid = 0; m1a.araddr = '0; m1a.arid = '0; m1a.arlen = '0;
    m1a.arsize = '0; m1a.arburst = '0; m1a.rready = 1;
    sa.arready = 1; sa.rvalid = 0; sa.rdata = '0; sa.rresp = '0; sa.rlast = 0; sa.rid = '0;
    m0b.arvalid = 0; m0b.araddr = '0; m0b.arid = '0; m0b.arlen = '0;
    m0b.arsize = '0; m0b.arburst = '0; m0b.rready = 1;
    m1b.arvalid = 0; m1b.araddr = '0; m1b.arid = '0; m1b.arlen = '0;
    m1b.arsize = '0; m1b.arburst = '0; m1b.rready = 1;
    sb.arready = 0; sb.rvalid = 0; sb.rdata = '0; sb.rresp = '0; sb.rlast = 0; sb.rid = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic set_ar(input int m, input logic v, input logic [31:0] a,
                        input logic [3:0] id, input logic [7:0] len);
    if (m == 1) begin
      m1a.arvalid = v; m1a.araddr = a; m1a.arid = id; m1a.arlen = len;
      m1a.arsize = AXI_SIZE_4B; m1a.arburst = AXI_BURST_INCR;
    end else begin
      m0a.arvalid = v; m0a.araddr = a; m0a.arid = id; m0a.arlen = len;
      m0a.arsize = AXI_SIZE_4B; m0a.arburst = AXI_BURST_INCR;
    end
  endtask

  task automatic set_arvalid(input int m, input logic v);
    if (m == 1) m1a.arvalid = v;
    else        m0a.arvalid = v;
  endtask

  // Polls for sa.arvalid with a 20-cycle budget; returns 2 ns after an edge.
  task automatic wait_ar(input string tag);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (sa.arvalid === 1'b1) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check1(tag, found, 1'b1);
  endtask

  task automatic check_ar(input int m, input logic [3:0] id, input logic [31:0] a);
    check32("ar_id", 32'(sa.arid), 32'(id));
    check32("ar_addr", sa.araddr, a);
    check1("ar_ready_granted", get_arready(m), sa.arready);
    check1("ar_ready_other", get_arready(1 - m), 1'b0);
    check1("ar_busy", busy_a, 1'b1);
  endtask

  // Called 1 ns after the AR handshake edge; delivers one last beat.
  task automatic r_single(input int m, input logic [3:0] id, input logic [31:0] d);
    set_arvalid(m, 0);
    sa.rvalid = 1; sa.rdata = d; sa.rid = id; sa.rresp = AXI_RESP_OKAY; sa.rlast = 1;
    #1;
    check1("r_valid", get_rvalid(m), 1'b1);
    check32("r_data", get_rdata(m), d);
    check1("r_other_valid", get_rvalid(1 - m), 1'b0);
    check1("r_s_rready", sa.rready, 1'b1);
    check1("r_busy", busy_a, 1'b1);
    check1("r_no_arvalid", sa.arvalid, 1'b0);
    @(posedge clk); #1;
    sa.rvalid = 0; sa.rlast = 0;
    #1;
    check1("r_done_busy", busy_a, 1'b0);
    check1("r_done_valid", get_rvalid(m), 1'b0);
  endtask

  task automatic serve(input int m, input logic [3:0] id, input logic [31:0] a,
                       input logic [31:0] d);
    wait_ar("serve_ar_timeout");
    check_ar(m, id, a);
    @(posedge clk); #1;
    r_single(m, id, d);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int hs;

    // Reset state
    do_reset();
    #1;
    check1("rst_busy", busy_a, 1'b0);
    check1("rst_s_arvalid", sa.arvalid, 1'b0);
    check1("rst_m0_arready", m0a.arready, 1'b0);
    check1("rst_m1_rvalid", m1a.rvalid, 1'b0);
    check1("rst_s_rready", sa.rready, 1'b0);

    // 1: m0 alone, one slave stall cycle so busy spans AR0, AR0, R0
    sa.arready = 0;
    set_ar(0, 1, 32'h8000_0000, 4'd3, 8'd0);
    #1;
    check1("t1_registered_grant", sa.arvalid, 1'b0);
    check1("t1_idle_busy", busy_a, 1'b0);
    wait_ar("t1_ar_timeout");
    check1("t1_stall_arready", m0a.arready, 1'b0);
    check1("t1_busy_c1", busy_a, 1'b1);
    @(posedge clk); #1;
    sa.arready = 1;
    #1;
    check1("t1_busy_c2", busy_a, 1'b1);
    check1("t1_m1_rvalid", m1a.rvalid, 1'b0);
    serve(0, 4'd3, 32'h8000_0000, 32'h0000_0413);

    // 2: simultaneous requests after reset alternate m0, m1, m0, m1
    do_reset();
    set_ar(0, 1, 32'h1000, 4'd1, 8'd0);
    set_ar(1, 1, 32'h2000, 4'd2, 8'd0);
    serve(0, 4'd1, 32'h1000, 32'hA0);
    set_ar(0, 1, 32'h1004, 4'd1, 8'd0);
    serve(1, 4'd2, 32'h2000, 32'hA1);
    set_ar(1, 1, 32'h2004, 4'd2, 8'd0);
    serve(0, 4'd1, 32'h1004, 32'hA2);
    serve(1, 4'd2, 32'h2004, 32'hA3);

    // 4: m1 burst len=3 with 2-cycle rready stalls; m0 raised mid-burst
    set_ar(1, 1, 32'h100, 4'd5, 8'd3);
    wait_ar("t4_ar_timeout");
    check_ar(1, 4'd5, 32'h100);
    @(posedge clk); #1;
    set_arvalid(1, 0);
    for (int b = 0; b < 4; b++) begin
      sa.rvalid = 1; sa.rdata = 32'hB0 + b; sa.rid = 4'd5; sa.rlast = (b == 3);
      m1a.rready = 0;
      if (b == 1) set_ar(0, 1, 32'h3000, 4'd6, 8'd0);
      for (int st = 0; st < 2; st++) begin
        #1;
        check1("t4_stall_rvalid", m1a.rvalid, 1'b1);
        check32("t4_stall_rdata", m1a.rdata, 32'hB0 + b);
        check1("t4_stall_s_rready", sa.rready, 1'b0);
        check1("t4_stall_m0_rvalid", m0a.rvalid, 1'b0);
        check1("t4_stall_s_arvalid", sa.arvalid, 1'b0);
        check1("t4_stall_m0_arready", m0a.arready, 1'b0);
        @(posedge clk); #1;
      end
      m1a.rready = 1;
      #1;
      check1("t4_beat_s_rready", sa.rready, 1'b1);
      check32("t4_beat_rdata", m1a.rdata, 32'hB0 + b);
      check1("t4_beat_rlast", m1a.rlast, (b == 3));
      @(posedge clk); #1;
    end
    sa.rvalid = 0; sa.rlast = 0;
    #1;
    check1("t4_bubble_busy", busy_a, 1'b0);
    check1("t4_bubble_s_arvalid", sa.arvalid, 1'b0);
    check1("t4_bubble_m1_rvalid", m1a.rvalid, 1'b0);
    @(posedge clk); #1;
    #1;
    check1("t4_m0_grant_arvalid", sa.arvalid, 1'b1);
    check32("t4_m0_grant_arid", 32'(sa.arid), 32'd6);
    serve(0, 4'd6, 32'h3000, 32'hC0);

    // 5: slave holds arready low for 5 cycles in AR0
    sa.arready = 0;
    set_ar(0, 1, 32'h4000, 4'd7, 8'd0);
    wait_ar("t5_ar_timeout");
    check32("t5_arid", 32'(sa.arid), 32'd7);
    set_ar(1, 1, 32'h5000, 4'd8, 8'd0);
    for (int i = 0; i < 5; i++) begin
      check32("t5_addr_stable", sa.araddr, 32'h4000);
      check1("t5_arvalid", sa.arvalid, 1'b1);
      check1("t5_m1_arready", m1a.arready, 1'b0);
      check1("t5_m0_arready", m0a.arready, 1'b0);
      @(posedge clk); #2;
    end
    sa.arready = 1;
    #1;
    check1("t5_m0_arready_release", m0a.arready, 1'b1);
    @(posedge clk); #1;
    r_single(0, 4'd7, 32'hD0);
    serve(1, 4'd8, 32'h5000, 32'hD1);

    // 6: reset in R1 after the first beat, then a fresh m0 read
    set_ar(1, 1, 32'h6000, 4'd9, 8'd1);
    wait_ar("t6_ar_timeout");
    check_ar(1, 4'd9, 32'h6000);
    @(posedge clk); #1;
    set_arvalid(1, 0);
    sa.rvalid = 1; sa.rdata = 32'hE0; sa.rid = 4'd9; sa.rlast = 0;
    #1;
    check1("t6_beat0_rvalid", m1a.rvalid, 1'b1);
    @(posedge clk); #1;
    sa.rdata = 32'hE1; sa.rlast = 1;
    #1;
    check1("t6_beat1_rvalid", m1a.rvalid, 1'b1);
    rst = 1;
    #1;
    check1("t6_rst_m1_rvalid", m1a.rvalid, 1'b0);
    check1("t6_rst_s_rready", sa.rready, 1'b0);
    check1("t6_rst_busy", busy_a, 1'b0);
    check1("t6_rst_s_arvalid", sa.arvalid, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    sa.rvalid = 0; sa.rlast = 0;
    set_ar(0, 1, 32'h7000, 4'd10, 8'd0);
    serve(0, 4'd10, 32'h7000, 32'hF0);

    // 3: FIX_PRIO=1, both masters request continuously
    do_reset();
    m0b.arvalid = 1; m0b.araddr = 32'h9000; m0b.arid = 4'd1;
    m1b.arvalid = 1; m1b.araddr = 32'hA000; m1b.arid = 4'd2;
    sb.arready = 1; sb.rvalid = 1; sb.rlast = 1; sb.rdata = 32'h55;
    hs = 0;
    for (int i = 0; i < 40 && hs < 4; i++) begin
      #1;
      if (sb.arvalid && sb.arready) begin
        check32("t3_grant_id", 32'(sb.arid), 32'd2);
        check1("t3_m0_arready", m0b.arready, 1'b0);
        check1("t3_m1_arready", m1b.arready, 1'b1);
        hs++;
      end
      if (m1b.rvalid) check1("t3_m0_rvalid", m0b.rvalid, 1'b0);
      @(posedge clk); #1;
    end
    check32("t3_grant_count", hs, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
